// File: rtl/pred_fb_gen.sv
// rtl/pred_fb_gen.sv - branch-prediction feedback producer with in-order in-flight queue
module pred_fb_gen #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          IF_pred_valid,
    input  logic          IF_pred_taken,
    input  logic [AW-1:0] IF_pred_target,
    output logic          IF_stall,
    input  logic          EX_branch_valid,
    input  logic          EX_actual_taken,
    input  logic [AW-1:0] EX_actual_target,
    input  logic [AW-1:0] EX_pc_plus4,
    input  logic          ext_flush,
    output logic          EX_feedback_valid,
    output logic          EX_prediction_incorrect,
    output logic          redirect_valid,
    output logic [AW-1:0] redirect_pc,
    output logic          err_overflow,
    output logic          err_underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic          mem_taken  [DEPTH];
    logic [AW-1:0] mem_target [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic full;
    logic empty;
    logic resolve;
    logic mispredict_now;
    logic pop_ok;
    logic push;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign IF_stall = full;

    assign resolve = EX_branch_valid && !empty && !ext_flush;
    // Not-taken predictions carry no meaningful target, so only taken outcomes compare it.
    assign mispredict_now = resolve &&
        ((mem_taken[rd_ptr] != EX_actual_taken) ||
         (EX_actual_taken && (mem_target[rd_ptr] != EX_actual_target)));
    assign pop_ok = resolve && !mispredict_now;
    assign push   = IF_pred_valid && !full && !ext_flush && !mispredict_now;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_taken[wr_ptr]  <= IF_pred_taken;
            mem_target[wr_ptr] <= IF_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr                  <= '0;
            wr_ptr                  <= '0;
            count                   <= '0;
            EX_feedback_valid       <= 1'b0;
            EX_prediction_incorrect <= 1'b0;
            redirect_valid          <= 1'b0;
            redirect_pc             <= '0;
            err_overflow            <= 1'b0;
            err_underflow           <= 1'b0;
        end else begin
            EX_feedback_valid       <= resolve;
            EX_prediction_incorrect <= mispredict_now;
            redirect_valid          <= mispredict_now;
            if (resolve)
                redirect_pc <= EX_actual_taken ? EX_actual_target : EX_pc_plus4;
            if (IF_pred_valid && full)
                err_overflow <= 1'b1;
            if (EX_branch_valid && empty)
                err_underflow <= 1'b1;

            // A mispredict makes every younger entry wrong-path, same as a flush.
            if (ext_flush || mispredict_now) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop_ok)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop_ok);
            end
        end
    end
endmodule

// File: tb/tb_pred_fb_gen.sv
// tb/tb_pred_fb_gen.sv - scoreboard bench for pred_fb_gen against a queue reference model
module tb_pred_fb_gen;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          IF_pred_valid = 1'b0;
    logic          IF_pred_taken = 1'b0;
    logic [AW-1:0] IF_pred_target = '0;
    logic          IF_stall;
    logic          EX_branch_valid = 1'b0;
    logic          EX_actual_taken = 1'b0;
    logic [AW-1:0] EX_actual_target = '0;
    logic [AW-1:0] EX_pc_plus4 = '0;
    logic          ext_flush = 1'b0;
    logic          EX_feedback_valid;
    logic          EX_prediction_incorrect;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          err_overflow;
    logic          err_underflow;

    pred_fb_gen #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_pred_valid(IF_pred_valid), .IF_pred_taken(IF_pred_taken),
        .IF_pred_target(IF_pred_target), .IF_stall(IF_stall),
        .EX_branch_valid(EX_branch_valid), .EX_actual_taken(EX_actual_taken),
        .EX_actual_target(EX_actual_target), .EX_pc_plus4(EX_pc_plus4),
        .ext_flush(ext_flush), .EX_feedback_valid(EX_feedback_valid),
        .EX_prediction_incorrect(EX_prediction_incorrect),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Model: in-flight predictions {taken, target}, oldest at index 0.
    logic [AW:0] model_q[$];
    // Expected feedback {incorrect, redirect_pc}, one entry per accepted resolve.
    logic [AW:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [AW-1:0] last_pc = '0;
    int checks = 0;
    int errs   = 0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic pv, input logic pt, input logic [AW-1:0] ptg,
                        input logic bv, input logic at, input logic [AW-1:0] atg,
                        input logic [AW-1:0] pc4, input logic fl);
        logic full_pre;
        logic mis;
        logic [AW:0] h;
        @(negedge clk);
        chk("if_stall", AW'(IF_stall), AW'(model_q.size() == DEPTH));
        chk("err_overflow", AW'(err_overflow), AW'(m_ovf));
        chk("err_underflow", AW'(err_underflow), AW'(m_unf));
        IF_pred_valid = pv; IF_pred_taken = pt; IF_pred_target = ptg;
        EX_branch_valid = bv; EX_actual_taken = at; EX_actual_target = atg;
        EX_pc_plus4 = pc4; ext_flush = fl;
        full_pre = (model_q.size() == DEPTH);
        mis = 1'b0;
        if (pv && full_pre) m_ovf = 1'b1;
        if (bv && model_q.size() == 0) m_unf = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (bv && model_q.size() > 0) begin
                h = model_q[0];
                mis = (h[AW] != at) || (at && h[AW-1:0] != atg);
                exp_q.push_back({mis, at ? atg : pc4});
                if (mis) model_q.delete();
                else void'(model_q.pop_front());
            end
            if (pv && !full_pre && !mis) model_q.push_back({pt, ptg});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic push_p(input logic pt, input logic [AW-1:0] ptg);
        step(1, pt, ptg, 0, 0, '0, '0, 0);
    endtask

    task automatic resolve(input logic at, input logic [AW-1:0] atg, input logic [AW-1:0] pc4);
        step(0, 0, '0, 1, at, atg, pc4, 0);
    endtask

    // Feedback monitor: checks every cycle just after the rising edge.
    initial begin
        logic [AW:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fb_valid", AW'(EX_feedback_valid), AW'(1));
                chk("fb_incorrect", AW'(EX_prediction_incorrect), AW'(e[AW]));
                chk("redirect_valid", AW'(redirect_valid), AW'(e[AW]));
                chk("redirect_pc", redirect_pc, e[AW-1:0]);
                last_pc = e[AW-1:0];
            end else begin
                chk("fb_valid_idle", AW'(EX_feedback_valid), AW'(0));
                chk("fb_incorrect_idle", AW'(EX_prediction_incorrect), AW'(0));
                chk("redirect_valid_idle", AW'(redirect_valid), AW'(0));
                chk("redirect_pc_hold", redirect_pc, last_pc);
            end
        end
    end

    initial begin
        logic pv, pt, bv, at, fl;
        logic [AW-1:0] ptg, atg, pc4;

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(5);

        push_p(1, 32'h100);
        resolve(1, 32'h100, 32'h8);
        idle(2);

        push_p(1, 32'h100);
        push_p(0, 32'h0);
        push_p(1, 32'h200);
        step(1, 1, 32'h500, 1, 1, 32'h104, 32'h4, 0);
        idle(2);

        push_p(0, 32'h0);
        resolve(1, 32'h300, 32'h10);
        push_p(0, 32'h0);
        resolve(0, 32'h0, 32'h44);
        idle(1);

        for (int i = 0; i < DEPTH; i++) push_p(1, 32'h1000 + 32'(i) * 4);
        push_p(1, 32'hdead);
        step(1, 1, 32'hbeef, 1, 1, 32'h1000, 32'h0, 0);
        for (int i = 1; i < DEPTH; i++) resolve(1, 32'h1000 + 32'(i) * 4, 32'h0);
        idle(1);
        push_p(1, 32'h2000);
        for (int i = 1; i <= 10; i++)
            step(1, 1, 32'h2000 + 32'(i) * 4, 1, 1, 32'h2000 + 32'(i - 1) * 4, 32'h0, 0);
        resolve(1, 32'h2000 + 32'd40, 32'h0);
        idle(1);

        resolve(1, 32'h600, 32'h0);
        push_p(1, 32'h700);
        push_p(0, 32'h0);
        step(1, 1, 32'h800, 1, 1, 32'h700, 32'h0, 1);
        idle(2);

        push_p(1, 32'h900);
        resolve(0, 32'h0, 32'h904);
        @(posedge clk);
        #2;
        IF_pred_valid = 0; EX_branch_valid = 0; ext_flush = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_fb_valid", AW'(EX_feedback_valid), AW'(0));
        chk("rst_incorrect", AW'(EX_prediction_incorrect), AW'(0));
        chk("rst_redirect_valid", AW'(redirect_valid), AW'(0));
        chk("rst_redirect_pc", redirect_pc, '0);
        chk("rst_err_overflow", AW'(err_overflow), AW'(0));
        chk("rst_err_underflow", AW'(err_underflow), AW'(0));
        model_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        last_pc = '0;
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        for (int n = 0; n < 400; n++) begin
            pv  = ($urandom_range(0, 99) < 60);
            pt  = 1'($urandom_range(0, 1));
            ptg = AW'($urandom_range(0, 7)) << 2;
            bv  = ($urandom_range(0, 99) < 45);
            fl  = ($urandom_range(0, 99) < 3);
            pc4 = AW'($urandom_range(0, 255)) << 2;
            if (model_q.size() > 0 && $urandom_range(0, 99) < 75) begin
                at  = model_q[0][AW];
                atg = at ? model_q[0][AW-1:0] : AW'($urandom_range(0, 7)) << 2;
            end else begin
                at  = 1'($urandom_range(0, 1));
                atg = AW'($urandom_range(0, 7)) << 2;
            end
            step(pv, pt, ptg, bv, at, atg, pc4, fl);
        end
        idle(3);
        chk("scoreboard_drained", AW'(exp_q.size()), AW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end
endmodule

// File: doc/pred_fb_gen.md
Name: pred_fb_gen

Overview:
- Producer side of the branch-prediction feedback interface.
- Records each prediction issued by IF in an in-order in-flight queue, then pops the oldest entry when EX resolves the branch.
- Compares predicted and actual outcome and drives EX_feedback_valid / EX_prediction_incorrect, plus a redirect to the PC mux.
- Its feedback outputs feed the prediction PMU counters and predictor training.

Parameters:
- DEPTH, 4, in-flight prediction entries; power of 2, minimum 2.
- AW, 32, PC/target width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IF_pred_valid  input  1  IF issued a prediction this cycle.
- IF_pred_taken  input  1  predicted direction.
- IF_pred_target  input  AW  predicted target; ignored when not taken.
- IF_stall  output  1  queue full; IF must hold. Combinational: count==DEPTH.
- EX_branch_valid  input  1  EX resolved the oldest branch this cycle.
- EX_actual_taken  input  1  resolved direction.
- EX_actual_target  input  AW  resolved taken target.
- EX_pc_plus4  input  AW  fall-through PC of the resolved branch.
- ext_flush  input  1  exception/trap flush; discards all in-flight entries.
- EX_feedback_valid  output  1  registered; one pulse per resolved branch.
- EX_prediction_incorrect  output  1  registered; qualified by EX_feedback_valid.
- redirect_valid  output  1  registered; equals EX_feedback_valid && EX_prediction_incorrect.
- redirect_pc  output  AW  registered correct next PC.
- err_overflow  output  1  sticky: push attempted while full.
- err_underflow  output  1  sticky: resolve attempted while empty.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; count=0; rd_ptr=wr_ptr=0; queue contents don't-care.
- Queue: circular, DEPTH entries of {taken, target}.
  - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
  - count is log2(DEPTH)+1 bits.
- Push accepted when IF_pred_valid && count<DEPTH && !ext_flush && !mispredict_now.
  - Stores {IF_pred_taken, IF_pred_target} at wr_ptr; wr_ptr++.
  - IF_pred_valid while full: push dropped; err_overflow set (sticky until reset).
- Resolve accepted when EX_branch_valid && count>0 && !ext_flush. Head entry compared combinationally:
  - mispredict_now = (head.taken != EX_actual_taken) || (EX_actual_taken && head.target != EX_actual_target).
  - Not-taken predictions never compare targets.
- Feedback latency is exactly 1 cycle after the resolve cycle:
  - EX_feedback_valid=1.
  - EX_prediction_incorrect=mispredict_now.
  - redirect_valid=mispredict_now.
  - redirect_pc = EX_actual_taken ? EX_actual_target : EX_pc_plus4.
- Outputs in all other cycles:
  - EX_feedback_valid=0, EX_prediction_incorrect=0, redirect_valid=0.
  - redirect_pc holds its last value.
- Correct resolve: pop only; rd_ptr++.
- Mispredict resolve: the whole queue is cleared at the edge (count=0, rd_ptr=wr_ptr). All younger entries are wrong-path. A same-cycle push is dropped.
- Push and correct resolve in the same cycle: count unchanged; both pointers advance.
- Push into a full queue is never accepted, even with a same-cycle pop. IF_stall depends only on count, which keeps the path free of combinational loops.
- EX_branch_valid with count==0: no feedback, no state change except err_underflow set. A same-cycle push does not satisfy it.
- ext_flush=1: queue cleared; same-cycle push and resolve ignored; no feedback next cycle. Sticky errors unaffected.
- Async reset mid-operation: immediate clear. An in-progress feedback pulse is lost.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, IF_stall=0.
- Push {taken=1, target=0x100}; next cycle resolve taken=1, target=0x100 -> one cycle later feedback_valid=1, incorrect=0, redirect_valid=0; count back to 0.
- Push 3 entries (T 0x100, NT, T 0x200); resolve first with actual target 0x104 -> feedback incorrect=1, redirect_pc=0x104; queue empty; push in the resolve cycle dropped.
- Push NT; resolve actual taken=1, target=0x300 -> incorrect=1, redirect_pc=0x300. Push NT; resolve NT with pc_plus4=0x44 -> incorrect=0.
- Fill DEPTH=4 -> IF_stall=1. 5th push -> err_overflow=1, count stays 4. Simultaneous push+correct pop at full -> count 3. Wrap pointers over 10 push/pop pairs -> order preserved.
- Resolve while empty -> err_underflow=1, no feedback. ext_flush with 2 entries plus same-cycle resolve -> count 0, no feedback. rst_n low mid-feedback -> outputs 0 asynchronously.
